// File: rtl/idli_sqi_mem_m.sv
// SQI memory responder: decodes serial-SRAM style quad-SPI read/write frames
// and serves byte data from an internal array.
module idli_sqi_mem_m #(
    parameter int DEPTH  = 65536,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst_n,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe
);

    // state   | meaning
    // S_IDLE  | waiting for chip select
    // S_CMD   | shifting in command byte
    // S_ADDR  | shifting in 24-bit address
    // S_DUMMY | dummy byte before read data
    // S_RDATA | streaming array bytes out on sck falls
    // S_WDATA | streaming bytes into the array on sck rises
    // S_SKIP  | unsupported command, wait for cs high
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_SKIP
    } state_t;

    logic [7:0]        r_mem [DEPTH];
    state_t            r_state;
    logic              r_sck_q;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_hi;
    logic              r_is_wr;
    logic              r_armed;
    logic [3:0]        r_sio;
    logic              r_sio_oe;

    logic              w_rise;
    logic              w_fall;
    logic              w_we;
    logic [7:0]        w_cmd;
    logic [7:0]        w_byte;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_rise     = i_mem_sck & ~r_sck_q & ~i_mem_cs;
    assign w_fall     = ~i_mem_sck & r_sck_q & ~i_mem_cs;
    assign w_cmd      = {r_hi, i_mem_sio};
    assign w_byte     = r_mem[r_addr];
    assign w_addr_inc = r_addr + ADDR_W'(1);
    assign w_we       = i_mem_rst_n & w_rise & (r_state == S_WDATA) & (r_cnt == 3'd1);

    assign o_mem_sio    = r_sio;
    assign o_mem_sio_oe = r_sio_oe;

    // Array has no reset; a partial byte never reaches here because w_we needs the low-nibble rise.
    always_ff @(posedge i_mem_gck) begin
        if (w_we) begin
            r_mem[r_addr] <= {r_hi, i_mem_sio};
        end
    end

    always_ff @(posedge i_mem_gck) begin
        if (!i_mem_rst_n) begin
            r_state  <= S_IDLE;
            r_sck_q  <= 1'b0;
            r_cnt    <= 3'd0;
            r_addr   <= '0;
            r_hi     <= 4'h0;
            r_is_wr  <= 1'b0;
            r_armed  <= 1'b0;
            r_sio    <= 4'h0;
            r_sio_oe <= 1'b0;
        end else begin
            r_sck_q <= i_mem_sck;
            if (i_mem_cs) begin
                r_state  <= S_IDLE;
                r_cnt    <= 3'd0;
                r_armed  <= 1'b1;
                r_sio    <= 4'h0;
                r_sio_oe <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // After a reset mid-frame, stay out until cs has been seen high.
                        if (r_armed) begin
                            r_state <= S_CMD;
                            r_cnt   <= 3'd0;
                        end
                    end
                    S_CMD: begin
                        if (w_rise) begin
                            if (r_cnt == 3'd0) begin
                                r_hi  <= i_mem_sio;
                                r_cnt <= 3'd1;
                            end else begin
                                r_cnt <= 3'd0;
                                case (w_cmd)
                                    8'h03: begin
                                        r_state <= S_ADDR;
                                        r_is_wr <= 1'b0;
                                    end
                                    8'h02: begin
                                        r_state <= S_ADDR;
                                        r_is_wr <= 1'b1;
                                    end
                                    default: r_state <= S_SKIP;
                                endcase
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_rise) begin
                            r_addr <= ADDR_W'({r_addr, i_mem_sio});
                            if (r_cnt == 3'd5) begin
                                r_cnt   <= 3'd0;
                                r_state <= r_is_wr ? S_WDATA : S_DUMMY;
                            end else begin
                                r_cnt <= r_cnt + 3'd1;
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (w_rise) begin
                            if (r_cnt == 3'd1) begin
                                r_cnt   <= 3'd0;
                                r_state <= S_RDATA;
                            end else begin
                                r_cnt <= 3'd1;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_fall) begin
                            r_sio_oe <= 1'b1;
                            if (r_cnt == 3'd0) begin
                                r_sio <= w_byte[7:4];
                                r_cnt <= 3'd1;
                            end else begin
                                r_sio  <= w_byte[3:0];
                                r_cnt  <= 3'd0;
                                r_addr <= w_addr_inc;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_rise) begin
                            if (r_cnt == 3'd0) begin
                                r_hi  <= i_mem_sio;
                                r_cnt <= 3'd1;
                            end else begin
                                r_cnt  <= 3'd0;
                                r_addr <= w_addr_inc;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Bench for idli_sqi_mem_m: table of read/write frames with a nibble scoreboard,
// plus hand sequences for partial writes, unknown commands and mid-frame reset.
module tb_idli_sqi_mem_m;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic [3:0] sio_i = 4'h0;
    logic [3:0] sio_o;
    logic       oe;

    int total = 0;
    int bad = 0;
    logic [3:0] exp_q[$];

    idli_sqi_mem_m #(.DEPTH(65536)) dut (
        .i_mem_gck    (clk),
        .i_mem_rst_n  (rst_n),
        .i_mem_sck    (sck),
        .i_mem_cs     (cs),
        .i_mem_sio    (sio_i),
        .o_mem_sio    (sio_o),
        .o_mem_sio_oe (oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        int          n;
        logic [23:0] data;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sck period: fall, hold low, sample outputs, rise, hold high.
    task automatic sck_cycle(input logic [3:0] nib, output logic [3:0] so, output logic soe);
        sck = 1'b0;
        sio_i = nib;
        wait_n(3);
        so = sio_o;
        soe = oe;
        sck = 1'b1;
        wait_n(3);
    endtask

    task automatic send_nib_oe0(input logic [3:0] nib, input string name);
        logic [3:0] so;
        logic soe;
        sck_cycle(nib, so, soe);
        check(name, 32'(soe), 32'd0);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        wait_n(2);
    endtask

    task automatic cs_high();
        sck = 1'b0;
        wait_n(1);
        cs = 1'b1;
        wait_n(3);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr, input bit dummy);
        send_nib_oe0(cmd[7:4], "oe_cmd");
        send_nib_oe0(cmd[3:0], "oe_cmd");
        for (int i = 5; i >= 0; i--) begin
            logic [3:0] nib;
            nib = 4'(addr >> (4 * i));
            send_nib_oe0(nib, "oe_addr");
        end
        if (dummy) begin
            send_nib_oe0(4'h0, "oe_dummy");
            send_nib_oe0(4'h0, "oe_dummy");
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b[7:4]);
        exp_q.push_back(b[3:0]);
    endtask

    task automatic read_bytes(input int n, input string name);
        logic [3:0] so;
        logic soe;
        for (int i = 0; i < 2 * n; i++) begin
            sck_cycle(4'h0, so, soe);
            check({name, "_oe"}, 32'(soe), 32'd1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s_sb got=empty want=entry", name);
            end else begin
                check(name, 32'(so), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic read_frame(input logic [23:0] addr, input int n, input logic [23:0] data,
                              input string name);
        cs_low();
        send_hdr(8'h03, addr, 1'b1);
        for (int k = 0; k < n; k++) begin
            push_byte(8'(data >> (16 - 8 * k)));
        end
        read_bytes(n, name);
        cs_high();
    endtask

    vec_t tbl[9];

    initial begin
        logic [3:0] so;
        logic soe;
        logic [3:0] rst_nibs[16];

        tbl[0] = '{1'b1, 24'h000010, 2, 24'hA53C00, "wr10"};
        tbl[1] = '{1'b0, 24'h000010, 2, 24'hA53C00, "rd10"};
        tbl[2] = '{1'b1, 24'h00FFFE, 3, 24'h112233, "wrwrap"};
        tbl[3] = '{1'b0, 24'h00FFFF, 2, 24'h223300, "rdwrap"};
        tbl[4] = '{1'b0, 24'h000000, 1, 24'h330000, "rd0"};
        tbl[5] = '{1'b1, 24'hFF0004, 1, 24'h5E0000, "wralias"};
        tbl[6] = '{1'b0, 24'h000004, 1, 24'h5E0000, "rdalias"};
        tbl[7] = '{1'b1, 24'h000020, 1, 24'h770000, "wr20"};
        tbl[8] = '{1'b0, 24'hAB0020, 1, 24'h770000, "rd20alias"};

        wait_n(3);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_sio", 32'(sio_o), 32'd0);
        rst_n = 1'b1;
        wait_n(2);

        for (int v = 0; v < 9; v++) begin
            if (tbl[v].wr) begin
                cs_low();
                send_hdr(8'h02, tbl[v].addr, 1'b0);
                for (int k = 0; k < tbl[v].n; k++) begin
                    logic [7:0] bt;
                    bt = 8'(tbl[v].data >> (16 - 8 * k));
                    send_nib_oe0(bt[7:4], {tbl[v].name, "_oe"});
                    send_nib_oe0(bt[3:0], {tbl[v].name, "_oe"});
                end
                cs_high();
            end else begin
                read_frame(tbl[v].addr, tbl[v].n, tbl[v].data, tbl[v].name);
            end
        end

        // Partial write: only the high nibble arrives before cs rises.
        cs_low();
        send_hdr(8'h02, 24'h000020, 1'b0);
        send_nib_oe0(4'h9, "partial_oe");
        cs_high();
        read_frame(24'h000020, 1, 24'h770000, "partial_rd");

        // Unknown command: responder stays silent, array untouched.
        cs_low();
        send_nib_oe0(4'hF, "skip_oe");
        send_nib_oe0(4'hF, "skip_oe");
        for (int i = 0; i < 20; i++) begin
            send_nib_oe0(4'hF, "skip_oe");
        end
        cs_high();
        read_frame(24'h000010, 2, 24'hA53C00, "skip_rd");

        // Reset in the middle of read data, then rest of frame looks like a fresh read.
        cs_low();
        send_hdr(8'h03, 24'h000010, 1'b1);
        sck_cycle(4'h0, so, soe);
        check("prerst_oe", 32'(soe), 32'd1);
        check("prerst_sio", 32'(so), 32'hA);
        rst_n = 1'b0;
        wait_n(1);
        check("midrst_oe", 32'(oe), 32'd0);
        check("midrst_sio", 32'(sio_o), 32'd0);
        rst_n = 1'b1;
        rst_nibs = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0,
                     4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 16; i++) begin
            send_nib_oe0(rst_nibs[i], "postrst_oe");
        end
        cs_high();
        read_frame(24'h000010, 2, 24'hA53C00, "postrst_rd");

        check("sb_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
